// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial packed-BCD adder with a three-state
// controller. One BCD digit is added per clock, lowest digit first; the
// result, decimal carry and a non-BCD error flag are published on entry to
// DONE and held until the next completion.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  // True when any 4-bit digit of the packed operand exceeds 9.
  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [1:0]   state_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         carry_r;
  logic [3:0]   idx_r;
  logic [W-1:0] work_r;

  logic [5:0]   shift_s;
  logic [3:0]   a_dig_s;
  logic [3:0]   b_dig_s;
  logic [4:0]   t_s;
  logic [4:0]   t_adj_s;
  logic [3:0]   dig_s;
  logic         carry_next_s;
  logic [W-1:0] work_next_s;

  // One-digit decimal add of the current digit, plus the working result
  // with that digit merged in (so the final edge can publish it directly).
  always_comb begin
    shift_s      = {idx_r, 2'b00};
    a_dig_s      = 4'(a_r >> shift_s);
    b_dig_s      = 4'(b_r >> shift_s);
    t_s          = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {4'b0000, carry_r};
    t_adj_s      = t_s + 5'd6;
    dig_s        = t_s[3:0];
    carry_next_s = 1'b0;
    if (t_s > 5'd9) begin
      dig_s        = t_adj_s[3:0];
      carry_next_s = 1'b1;
    end else begin
      dig_s        = t_s[3:0];
      carry_next_s = 1'b0;
    end
    work_next_s = (work_r & ~(W'(4'hF) << shift_s)) | (W'(dig_s) << shift_s);
  end

  // Controller, operand capture, digit iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= 4'd0;
      work_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= 4'd0;
            work_r  <= '0;
            if (has_non_bcd(a) || has_non_bcd(b)) begin
              // Invalid operands skip the adder entirely.
              state_r <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              sum     <= '0;
              cout    <= 1'b0;
            end else begin
              state_r <= ADD;
              busy    <= 1'b1;
            end
          end
        end
        ADD: begin
          work_r  <= work_next_s;
          carry_r <= carry_next_s;
          idx_r   <= idx_r + 4'd1;
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= work_next_s;
            cout    <= carry_next_s;
            err     <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on clk rising edges.
REQ-005 The block SHALL have port a, input, 4*DIGITS bits: packed BCD operand A, digit 0 in bits [3:0].
REQ-006 The block SHALL have port b, input, 4*DIGITS bits: packed BCD operand B, with the same packing as a.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into digit 0.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the state is ADD.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port sum, output, 4*DIGITS bits: packed BCD result, registered.
REQ-011 The block SHALL have port cout, output, 1 bit: decimal carry out of the most significant digit, registered.
REQ-012 The block SHALL have port err, output, 1 bit: the last accepted operand pair contained a non-BCD digit (>9).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-014 In IDLE, when start=1 is sampled, the block SHALL capture a, b and cin into internal registers on that edge.
REQ-015 On that capture edge, the block SHALL clear the digit index to 0 and the working carry to cin.
REQ-016 On that capture edge, the block SHALL go to ADD when every digit of a and b is <=9.
REQ-017 If any captured digit is >9, the block SHALL go directly to DONE with err=1, sum=0 and cout=0, and SHALL perform no additions.
REQ-018 In ADD, each edge SHALL process one digit i, lowest digit first: t = a_i + b_i + c, evaluated in 5 bits.
REQ-019 For t>9, the block SHALL write result digit (t+6)[3:0] and set c=1; otherwise it SHALL write t[3:0] and set c=0.
REQ-020 The digit index SHALL increment by 1 per ADD edge; after the edge that processes digit DIGITS-1, the state SHALL become DONE.
REQ-021 On entry to DONE, sum SHALL take the full working result, cout SHALL take the final c, and err SHALL take 0 on the valid path.
REQ-022 sum, cout and err SHALL be updated only on entry to DONE, and SHALL hold their values until the next entry to DONE.
REQ-023 done SHALL be 1 only while in DONE, which SHALL last exactly one cycle, followed unconditionally by IDLE.
REQ-024 Latency on the valid path SHALL be DIGITS+1 edges from the start-sampling edge to the edge that sets done=1; on the error path it SHALL be 1 edge.
REQ-025 start SHALL be ignored in ADD and in DONE; it is not queued, and a start held high through DONE is accepted on the first IDLE edge.
REQ-026 Changes on a, b or cin after the capture edge SHALL NOT affect the operation in progress.
REQ-027 The block SHALL be throughput-limited to one operation per DIGITS+2 cycles (valid path).

Reset
REQ-028 When rst_n=0 is sampled, the block SHALL go to IDLE and clear busy, done, sum, cout, err, the digit index, the carry and the captured operands to 0.
REQ-029 A reset sampled mid-ADD or in DONE SHALL abort the operation; no done pulse SHALL follow and no result SHALL be published.
REQ-030 When rst_n=0 and start=1 are sampled on the same edge, reset SHALL win and start SHALL be dropped.

Verification
REQ-031 The bench SHALL cover: DIGITS=4, a=0x1234, b=0x5678, cin=0, start one cycle -> busy for 4 cycles, done on 5th edge, sum=0x6912, cout=0, err=0.
REQ-032 The bench SHALL cover: a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, and a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
REQ-033 The bench SHALL cover: a=0x12A4, b=0x0000 -> done on the 1st edge after start, err=1, sum=0x0000, cout=0, busy never high.
REQ-034 The bench SHALL cover: start re-pulsed with a=0x1111, b=0x1111 during ADD of 0x1234+0x5678 -> ignored, result 0x6912, single done pulse.
REQ-035 The bench SHALL cover: rst_n low on the 2nd ADD edge of 0x9999+0x9999 -> all outputs 0 on the next cycle, no done, next start with 0x0005+0x0004 -> sum=0x0009.
REQ-036 The bench SHALL cover: start held high continuously with a=0x0099, b=0x0001 -> a new operation every 6 cycles, each with sum=0x0100, cout=0.
